// File: rtl/plru_replacer_if.sv
// plru_replacer_if: request/response bundle between hit detector and PLRU replacer.
// master = requester side, slave = replacer side.
interface plru_replacer_if #(
    parameter int ways      = 8,
    parameter int indexBits = 14
);
    localparam int wayBits = (ways > 1) ? $clog2(ways) : 1;

    logic                 req_valid;
    logic                 req_ready;
    logic [indexBits-1:0] req_index;
    logic [ways-1:0]      req_hitVec;
    logic [ways-1:0]      req_validVec;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [wayBits-1:0]   resp_way;
    logic                 resp_hit;
    logic                 resp_evict;
    logic                 resp_multiHit;

    modport master (
        output req_valid, req_index, req_hitVec, req_validVec, resp_ready,
        input  req_ready, resp_valid, resp_way, resp_hit, resp_evict,
        input  resp_multiHit
    );

    modport slave (
        input  req_valid, req_index, req_hitVec, req_validVec, resp_ready,
        output req_ready, resp_valid, resp_way, resp_hit, resp_evict,
        output resp_multiHit
    );
endinterface

// File: rtl/plru_replacer.sv
// plru_replacer: per-set tree pseudo-LRU way selector owning the PLRU state array.
// Ports: clk, reset_n (async, active low), bus (slave: req in, resp out).
module plru_replacer #(
    parameter int ways      = 8,
    parameter int indexBits = 14
) (
    input  logic           clk,
    input  logic           reset_n,
    plru_replacer_if.slave bus
);
    localparam int wayBits = (ways > 1) ? $clog2(ways) : 1;
    localparam int sets    = 1 << indexBits;
    localparam int nodes   = ways - 1;
    localparam logic [indexBits-1:0] idx_one = 1;
    localparam logic [wayBits:0]     node_one = 1;

    typedef enum logic [2:0] {
        INIT, IDLE, LOOKUP, CALC, RESP
    } state_t;

    state_t               state;
    logic [indexBits-1:0] sweep;
    logic [indexBits-1:0] idx_q;
    logic [ways-1:0]      hit_q;
    logic [ways-1:0]      vld_q;
    logic [nodes-1:0]     tree_q;
    logic [nodes-1:0]     mem [sets];

    logic                 rdy_q;
    logic                 rv_q;
    logic [wayBits-1:0]   way_q;
    logic                 hit_o;
    logic                 evict_o;
    logic                 multi_o;

    logic [wayBits-1:0]   victim;
    logic [wayBits:0]     node_v;
    logic                 dir_v;
    logic [wayBits-1:0]   lo_hit;
    logic [wayBits-1:0]   lo_free;
    logic [wayBits-1:0]   sel_way;
    logic                 sel_evict;
    logic [nodes-1:0]     new_tree;
    logic [wayBits:0]     node_t;
    logic                 dir_t;

    logic                 mem_we;
    logic [indexBits-1:0] mem_addr;
    logic [nodes-1:0]     mem_wdata;

    // Victim walk: follow node bits from the root; path bits form the way.
    always_comb begin
        victim = '0;
        node_v = '0;
        dir_v  = 1'b0;
        for (int l = 0; l < wayBits; l++) begin
            dir_v = tree_q[node_v[wayBits-1:0]];
            victim[wayBits-1-l] = dir_v;
            node_v = {node_v[wayBits-1:0], 1'b0} + node_one
                   + {{wayBits{1'b0}}, dir_v};
        end
    end

    always_comb begin
        lo_hit  = '0;
        lo_free = '0;
        for (int i = ways - 1; i >= 0; i--) begin
            if (hit_q[i])  lo_hit  = i[wayBits-1:0];
            if (!vld_q[i]) lo_free = i[wayBits-1:0];
        end
        sel_evict = 1'b0;
        if (|hit_q) begin
            sel_way = lo_hit;
        end else if (!(&vld_q)) begin
            sel_way = lo_free;
        end else begin
            sel_way   = victim;
            sel_evict = 1'b1;
        end
    end

    // Touch: every node on the path points away from the selected way.
    always_comb begin
        new_tree = tree_q;
        node_t   = '0;
        dir_t    = 1'b0;
        for (int l = 0; l < wayBits; l++) begin
            dir_t = sel_way[wayBits-1-l];
            new_tree[node_t[wayBits-1:0]] = ~dir_t;
            node_t = {node_t[wayBits-1:0], 1'b0} + node_one
                   + {{wayBits{1'b0}}, dir_t};
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = idx_q;
        mem_wdata = new_tree;
        if (reset_n && state == INIT) begin
            mem_we    = 1'b1;
            mem_addr  = sweep;
            mem_wdata = '0;
        end else if (reset_n && state == CALC) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (state == LOOKUP) tree_q <= mem[idx_q];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= INIT;
            sweep   <= '0;
            idx_q   <= '0;
            hit_q   <= '0;
            vld_q   <= '0;
            rdy_q   <= 1'b0;
            rv_q    <= 1'b0;
            way_q   <= '0;
            hit_o   <= 1'b0;
            evict_o <= 1'b0;
            multi_o <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    sweep <= sweep + idx_one;
                    if (sweep == '1) begin
                        state <= IDLE;
                        rdy_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.req_valid && rdy_q) begin
                        idx_q <= bus.req_index;
                        hit_q <= bus.req_hitVec;
                        vld_q <= bus.req_validVec;
                        rdy_q <= 1'b0;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: state <= CALC;
                CALC: begin
                    way_q   <= sel_way;
                    hit_o   <= |hit_q;
                    evict_o <= sel_evict;
                    multi_o <= ($countones(hit_q) > 1);
                    rv_q    <= 1'b1;
                    state   <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        rv_q  <= 1'b0;
                        rdy_q <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    assign bus.req_ready     = rdy_q;
    assign bus.resp_valid    = rv_q;
    assign bus.resp_way      = way_q;
    assign bus.resp_hit      = hit_o;
    assign bus.resp_evict    = evict_o;
    assign bus.resp_multiHit = multi_o;
endmodule

// File: tb/tb_plru_replacer.sv
// tb_plru_replacer: randomized and directed bench for plru_replacer.
// Reference model keeps per-set node bits and walks the heap tree arithmetically.
module tb_plru_replacer;
    localparam int W    = 8;
    localparam int IB   = 4;
    localparam int SETS = 1 << IB;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    plru_replacer_if #(.ways(W), .indexBits(IB)) bus ();

    plru_replacer #(.ways(W), .indexBits(IB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit tm [SETS][W-1];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int victim_of(input int s);
        int i;
        i = 0;
        while (i < W - 1) i = 2 * i + 1 + int'(tm[s][i]);
        return i - (W - 1);
    endfunction

    function automatic void touch(input int s, input int w);
        int c;
        int p;
        c = w + W - 1;
        while (c > 0) begin
            p = (c - 1) / 2;
            tm[s][p] = (c == 2 * p + 1);
            c = p;
        end
    endfunction

    task automatic count_init(input string tag);
        int n;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.req_ready) break;
        end
        check(tag, n, 16);
    endtask

    task automatic do_req(input int s, input logic [W-1:0] hv,
                          input logic [W-1:0] vv, input int hold);
        int ew;
        bit eh, ee, em;
        int n;
        int lat;
        logic [2:0] w0;
        ew = 0; eh = 0; ee = 0; em = 0;
        if (hv != 0) begin
            for (int i = W - 1; i >= 0; i--) if (hv[i]) ew = i;
            eh = 1;
            em = ($countones(hv) > 1);
        end else if (vv != {W{1'b1}}) begin
            for (int i = W - 1; i >= 0; i--) if (!vv[i]) ew = i;
        end else begin
            ew = victim_of(s);
            ee = 1;
        end
        touch(s, ew);

        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check("req_ready_timeout", 0, 1);
            return;
        end
        bus.req_valid    = 1'b1;
        bus.req_index    = s[IB-1:0];
        bus.req_hitVec   = hv;
        bus.req_validVec = vv;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", lat, 3);
        check("resp_way", bus.resp_way, ew);
        check("resp_hit", bus.resp_hit, eh);
        check("resp_evict", bus.resp_evict, ee);
        check("resp_multiHit", bus.resp_multiHit, em);
        w0 = bus.resp_way;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", bus.resp_valid, 1);
            check("hold_way", bus.resp_way, w0);
            check("hold_ready", bus.req_ready, 0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("valid_drop", bus.resp_valid, 0);
        check("ready_back", bus.req_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] vv;
        logic [W-1:0] hv;
        int r;
        bus.req_valid    = 1'b0;
        bus.req_index    = '0;
        bus.req_hitVec   = '0;
        bus.req_validVec = '0;
        bus.resp_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_way", bus.resp_way, 0);
        check("rst_flags", {bus.resp_hit, bus.resp_evict, bus.resp_multiHit}, 0);

        reset_n = 1'b1;
        count_init("init_sweep");

        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        check("midsweep_rst_ready", bus.req_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        count_init("init_sweep_restart");

        for (int s = 0; s < SETS; s++)
            for (int j = 0; j < W - 1; j++) tm[s][j] = 0;

        do_req(3, 8'h00, 8'hFF, 0);
        do_req(3, 8'h00, 8'hFF, 0);
        do_req(3, 8'h00, 8'hFF, 0);
        do_req(5, 8'h00, 8'hF7, 0);
        do_req(5, 8'h00, 8'hFF, 0);
        do_req(9, 8'h01, 8'hFF, 0);
        do_req(9, 8'h00, 8'hFF, 0);
        do_req(10, 8'h00, 8'hFF, 0);
        do_req(12, 8'h24, 8'hFF, 0);
        do_req(12, 8'h00, 8'hFF, 5);

        repeat (150) begin
            r = $urandom_range(0, 9);
            vv = (r < 6) ? 8'hFF : W'($urandom);
            r = $urandom_range(0, 3);
            if (r < 2) hv = '0;
            else if (r == 2) hv = (8'h01 << $urandom_range(0, W - 1)) & vv;
            else hv = W'($urandom) & vv;
            do_req($urandom_range(0, SETS - 1), hv, vv, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
